// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter/sequencer for the shared select decoder: grants one master,
// holds the decoder address/enable until ack or timeout, then pulses a response.
module decoder_select_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rvalid_o,
    output logic                        err_o,
    output logic [ADDR_W-1:0]           dec_addr_o,
    output logic                        dec_en_o,
    input  logic                        ack_i,
    output logic                        busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   dec_addr_q, dec_addr_d;
    logic                dec_en_q, dec_en_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [IDX_W-1:0]    win;
    logic [NUM_REQ-1:0]  win_oh;
    logic [NUM_REQ-1:0]  last_oh;

    // First requester strictly after the previous winner, wrapping around.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] cand;
        logic             found;
        int               idx;
        w     = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(last) + i) % NUM_REQ;
            cand = idx[IDX_W-1:0];
            if (!found && req[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        for (int m = 0; m < NUM_REQ; m++) begin
            addr_arr[m] = addr_i[m*ADDR_W +: ADDR_W];
        end
    end

    assign win     = pick(req_i, last_q);
    assign win_oh  = NUM_REQ'(1) << win;
    assign last_oh = NUM_REQ'(1) << last_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        err_d      = 1'b0;
        dec_addr_d = dec_addr_q;
        dec_en_d   = dec_en_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d      = win_oh;
                    dec_addr_d = addr_arr[win];
                    dec_en_d   = 1'b1;
                    last_d     = win;
                    cnt_d      = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (ack_i) begin
                    rvalid_d = last_oh;
                    dec_en_d = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rvalid_d = last_oh;
                    err_d    = 1'b1;
                    dec_en_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                dec_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            err_q      <= 1'b0;
            dec_addr_q <= '0;
            dec_en_q   <= 1'b0;
            cnt_q      <= '0;
            last_q     <= LAST_RST;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            dec_addr_q <= dec_addr_d;
            dec_en_q   <= dec_en_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign rvalid_o   = rvalid_q;
    assign err_o      = err_q;
    assign dec_addr_o = dec_addr_q;
    assign dec_en_o   = dec_en_q;
    assign busy_o     = (state_q != IDLE);

endmodule
